// File: rtl/tetris_pkg.sv
// tetris_pkg: shared constants for the tetris game-flow controller.
//   - Board geometry (BOARD_ROWS, BOARD_COLS).
//   - Sequencer state encoding as plain 3-bit constants, which keeps it
//     compatible with existing code that stores or compares raw state bits.
//   - Bit positions of the command strobes inside the sequencer's
//     registered command vector.
// No ports (package).
package tetris_pkg;

    localparam int BOARD_ROWS = 23;
    localparam int BOARD_COLS = 10;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_SPAWN = 3'd1;
    localparam logic [2:0] ST_CHECK = 3'd2;
    localparam logic [2:0] ST_FALL  = 3'd3;
    localparam logic [2:0] ST_LOCK  = 3'd4;
    localparam logic [2:0] ST_SCAN  = 3'd5;
    localparam logic [2:0] ST_CLEAR = 3'd6;
    localparam logic [2:0] ST_OVER  = 3'd7;

    localparam int CMD_LOAD   = 0;
    localparam int CMD_DOWN   = 1;
    localparam int CMD_LEFT   = 2;
    localparam int CMD_RIGHT  = 3;
    localparam int CMD_ROTATE = 4;
    localparam int CMD_LOCK   = 5;
    localparam int CMD_CLEAR  = 6;
    localparam int CMD_NUM    = 7;

endpackage

// File: rtl/tetris_sequencer_key_edge_detect.sv
// key_edge_detect: registered rising-edge detector for the three move keys.
// The previous level of each key is registered every cycle, so a key that is
// held produces exactly one rise pulse, in the cycle it first reads high.
// Ports:
//   clock_framerate  in   game clock
//   resetn           in   synchronous active-low reset (history cleared to 0)
//   keys[2:0]        in   raw key levels {rotate, right, left}
//   rise[2:0]        out  combinational rising-edge flags, same bit order
module key_edge_detect (
    input  logic       clock_framerate,
    input  logic       resetn,
    input  logic [2:0] keys,
    output logic [2:0] rise
);

    logic [2:0] prev;

    always_ff @(posedge clock_framerate) begin
        if (!resetn) prev <= '0;
        else         prev <= keys;
    end

    assign rise = keys & ~prev;

endmodule

// File: rtl/tetris_sequencer.sv
// tetris_sequencer: game-flow controller for the tetris datapath.
// Spawns pieces, arbitrates gravity against player moves, applies lock delay,
// scans and clears full rows and detects game over.
//
// Command strobes are registered and describe the phase being entered: the
// edge that moves the sequencer into SPAWN raises cmd_load for the SPAWN
// cycle, so the datapath's spawn_blocked answer is valid in the following
// CHECK cycle. Likewise cmd_lock is high during LOCK and cmd_clear during
// CLEAR; move strobes (down/left/right/rotate) appear the cycle after FALL
// made the decision. At most one strobe is high in any cycle.
//
// Optional feature: define TETRIS_SOFT_DROP_EN to make a held key_down act as
// a gravity tick every FALL cycle (below fall_tick, above the move keys).
// Without it key_down is ignored.
//
// Ports:
//   clock_framerate          in   game clock
//   resetn                   in   synchronous active-low reset
//   start_game               in   level, starts a game from IDLE or OVER
//   fall_tick                in   one-cycle gravity pulse
//   key_left/right/rotate    in   raw key levels
//   key_down                 in   raw level, soft drop (optional feature)
//   filled_under/left/right  in   piece blocked below/left/right
//   rotation_conflicts       in   rotated piece would collide
//   spawn_blocked            in   freshly loaded piece overlaps the board
//   row_full                 in   board row scan_row fully occupied
//   cmd_load..cmd_clear      out  one-cycle command strobes
//   scan_row[4:0]            out  row under inspection
//   game_over                out  high while in OVER
//   lines_cleared[CNT_W-1:0] out  rows cleared this game, wraps
module tetris_sequencer
    import tetris_pkg::*;
#(
    parameter int ROWS       = BOARD_ROWS,
    parameter int LOCK_TICKS = 2,
    parameter int CNT_W      = 16
) (
    input  logic             clock_framerate,
    input  logic             resetn,
    input  logic             start_game,
    input  logic             fall_tick,
    input  logic             key_left,
    input  logic             key_right,
    input  logic             key_rotate,
    input  logic             key_down,
    input  logic             filled_under,
    input  logic             filled_left,
    input  logic             filled_right,
    input  logic             rotation_conflicts,
    input  logic             spawn_blocked,
    input  logic             row_full,
    output logic             cmd_load,
    output logic             cmd_down,
    output logic             cmd_left,
    output logic             cmd_right,
    output logic             cmd_rotate,
    output logic             cmd_lock,
    output logic             cmd_clear,
    output logic [4:0]       scan_row,
    output logic             game_over,
    output logic [CNT_W-1:0] lines_cleared
);

    localparam int LW = $clog2(LOCK_TICKS + 1);

    logic [2:0]         state;
    logic [CMD_NUM-1:0] cmd;
    logic [LW-1:0]      lock_cnt;
    logic [LW-1:0]      lock_nxt;
    logic [2:0]         rise;
    logic               gravity;

    key_edge_detect u_key_edge (
        .clock_framerate (clock_framerate),
        .resetn          (resetn),
        .keys            ({key_rotate, key_right, key_left}),
        .rise            (rise)
    );

`ifdef TETRIS_SOFT_DROP_EN
    assign gravity = fall_tick | key_down;
`else
    assign gravity = fall_tick;
    logic unused_key_down;
    assign unused_key_down = key_down;
`endif

    assign lock_nxt = lock_cnt + LW'(1);

    always_ff @(posedge clock_framerate) begin
        if (!resetn) begin
            state         <= ST_IDLE;
            cmd           <= '0;
            scan_row      <= '0;
            lock_cnt      <= '0;
            lines_cleared <= '0;
            game_over     <= 1'b0;
        end else begin
            cmd <= '0;
            case (state)
                ST_IDLE, ST_OVER: begin
                    if (start_game) begin
                        state          <= ST_SPAWN;
                        cmd[CMD_LOAD]  <= 1'b1;
                        lines_cleared  <= '0;
                        game_over      <= 1'b0;
                    end
                end
                ST_SPAWN: state <= ST_CHECK;
                ST_CHECK: begin
                    if (spawn_blocked) begin
                        state     <= ST_OVER;
                        game_over <= 1'b1;
                    end else begin
                        state    <= ST_FALL;
                        lock_cnt <= '0;
                    end
                end
                ST_FALL: begin
                    // Gravity wins the cycle; a key edge arriving with it is lost.
                    if (gravity) begin
                        if (!filled_under) begin
                            cmd[CMD_DOWN] <= 1'b1;
                            lock_cnt      <= '0;
                        end else begin
                            lock_cnt <= lock_nxt;
                            if (lock_nxt == LW'(LOCK_TICKS)) begin
                                state         <= ST_LOCK;
                                cmd[CMD_LOCK] <= 1'b1;
                            end
                        end
                    end else if (rise[0] && !filled_left) begin
                        cmd[CMD_LEFT] <= 1'b1;
                    end else if (rise[1] && !filled_right) begin
                        cmd[CMD_RIGHT] <= 1'b1;
                    end else if (rise[2] && !rotation_conflicts) begin
                        cmd[CMD_ROTATE] <= 1'b1;
                    end
                end
                ST_LOCK: begin
                    state    <= ST_SCAN;
                    scan_row <= '0;
                end
                ST_SCAN: begin
                    if (row_full) begin
                        state          <= ST_CLEAR;
                        cmd[CMD_CLEAR] <= 1'b1;
                        lines_cleared  <= lines_cleared + CNT_W'(1);
                    end else if (scan_row == 5'(ROWS - 1)) begin
                        state         <= ST_SPAWN;
                        cmd[CMD_LOAD] <= 1'b1;
                    end else begin
                        scan_row <= scan_row + 5'd1;
                    end
                end
                // scan_row is held so the row that received the shifted-down
                // contents is inspected again.
                ST_CLEAR: state <= ST_SCAN;
                default:  state <= ST_IDLE;
            endcase
        end
    end

    assign cmd_load   = cmd[CMD_LOAD];
    assign cmd_down   = cmd[CMD_DOWN];
    assign cmd_left   = cmd[CMD_LEFT];
    assign cmd_right  = cmd[CMD_RIGHT];
    assign cmd_rotate = cmd[CMD_ROTATE];
    assign cmd_lock   = cmd[CMD_LOCK];
    assign cmd_clear  = cmd[CMD_CLEAR];

endmodule

// File: tb/tb_tetris_sequencer.sv
// tb_tetris_sequencer: bench for tetris_sequencer.
// A behavioural game model predicts every output each cycle; a compare
// process checks the DUT against it on the falling edge. Directed scenarios
// add literal expectations, followed by a randomized run.
module tb_tetris_sequencer;

    localparam int ROWS       = 23;
    localparam int LOCK_TICKS = 2;
    localparam int CNT_W      = 16;

    logic clock_framerate = 1'b0;
    logic resetn = 1'b0, start_game = 1'b0, fall_tick = 1'b0;
    logic key_left = 1'b0, key_right = 1'b0, key_rotate = 1'b0, key_down = 1'b0;
    logic filled_under = 1'b0, filled_left = 1'b0, filled_right = 1'b0;
    logic rotation_conflicts = 1'b0, spawn_blocked = 1'b0, row_full = 1'b0;
    logic cmd_load, cmd_down, cmd_left, cmd_right, cmd_rotate, cmd_lock, cmd_clear;
    logic [4:0] scan_row;
    logic game_over;
    logic [CNT_W-1:0] lines_cleared;

    always #5 clock_framerate = ~clock_framerate;

    tetris_sequencer #(.ROWS(ROWS), .LOCK_TICKS(LOCK_TICKS), .CNT_W(CNT_W)) dut (
        .clock_framerate(clock_framerate), .resetn(resetn), .start_game(start_game),
        .fall_tick(fall_tick), .key_left(key_left), .key_right(key_right),
        .key_rotate(key_rotate), .key_down(key_down), .filled_under(filled_under),
        .filled_left(filled_left), .filled_right(filled_right),
        .rotation_conflicts(rotation_conflicts), .spawn_blocked(spawn_blocked),
        .row_full(row_full), .cmd_load(cmd_load), .cmd_down(cmd_down),
        .cmd_left(cmd_left), .cmd_right(cmd_right), .cmd_rotate(cmd_rotate),
        .cmd_lock(cmd_lock), .cmd_clear(cmd_clear), .scan_row(scan_row),
        .game_over(game_over), .lines_cleared(lines_cleared)
    );

    int tests = 0, fails = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef enum {P_IDLE, P_SPAWN, P_CHECK, P_FALL, P_LOCK, P_SCAN, P_CLEAR, P_OVER} phase_t;
    phase_t ph = P_IDLE;
    int grounded = 0, row = 0;
    int unsigned lines = 0;
    bit over = 0, armed = 0;
    bit hist_l = 0, hist_r = 0, hist_rot = 0;
    bit x_load, x_down, x_left, x_right, x_rot, x_lock, x_clear;

    always @(posedge clock_framerate) begin
        bit el, er, erot, grav;
        el = key_left && !hist_l;
        er = key_right && !hist_r;
        erot = key_rotate && !hist_rot;
        hist_l = key_left; hist_r = key_right; hist_rot = key_rotate;
        grav = fall_tick;
`ifdef TETRIS_SOFT_DROP_EN
        grav = grav || key_down;
`endif
        {x_load, x_down, x_left, x_right, x_rot, x_lock, x_clear} = '0;
        if (!resetn) begin
            ph = P_IDLE; grounded = 0; row = 0; lines = 0; over = 0;
            hist_l = 0; hist_r = 0; hist_rot = 0; armed = 1;
        end else begin
            case (ph)
                P_IDLE, P_OVER:
                    if (start_game) begin ph = P_SPAWN; x_load = 1; lines = 0; over = 0; end
                P_SPAWN: ph = P_CHECK;
                P_CHECK:
                    if (spawn_blocked) begin ph = P_OVER; over = 1; end
                    else begin ph = P_FALL; grounded = 0; end
                P_FALL:
                    if (grav) begin
                        if (!filled_under) begin x_down = 1; grounded = 0; end
                        else begin
                            grounded++;
                            if (grounded >= LOCK_TICKS) begin ph = P_LOCK; x_lock = 1; end
                        end
                    end
                    else if (el && !filled_left) x_left = 1;
                    else if (er && !filled_right) x_right = 1;
                    else if (erot && !rotation_conflicts) x_rot = 1;
                P_LOCK: begin ph = P_SCAN; row = 0; end
                P_SCAN:
                    if (row_full) begin ph = P_CLEAR; x_clear = 1; lines = (lines + 1) % (1 << CNT_W); end
                    else if (row == ROWS - 1) begin ph = P_SPAWN; x_load = 1; end
                    else row++;
                P_CLEAR: ph = P_SCAN;
                default: ph = P_IDLE;
            endcase
        end
    end

    // ---------------- compare + strobe counters ----------------
    int n_load = 0, n_down = 0, n_left = 0, n_right = 0, n_lock = 0, n_clear = 0, n_all = 0;

    always @(negedge clock_framerate) begin
        logic [6:0] got_cmd;
        if (armed) begin
            got_cmd = {cmd_load, cmd_down, cmd_left, cmd_right, cmd_rotate, cmd_lock, cmd_clear};
            chk("strobes", {25'd0, got_cmd},
                {25'd0, x_load, x_down, x_left, x_right, x_rot, x_lock, x_clear});
            chk("one_strobe_max", {31'd0, $countones(got_cmd) <= 1}, 32'd1);
            chk("scan_row", {27'd0, scan_row}, row);
            chk("game_over", {31'd0, game_over}, {31'd0, over});
            chk("lines_cleared", {16'd0, lines_cleared}, lines);
            n_load  += int'(cmd_load);
            n_down  += int'(cmd_down);
            n_left  += int'(cmd_left);
            n_right += int'(cmd_right);
            n_lock  += int'(cmd_lock);
            n_clear += int'(cmd_clear);
            n_all   += $countones(got_cmd);
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(negedge clock_framerate);
        #1;
    endtask

    task automatic wait_row(input int r);
        for (int i = 0; i < 40 && scan_row !== 5'(r); i++) tick();
        chk("reach_row", {27'd0, scan_row}, r);
    endtask

    task automatic wait_load();
        for (int i = 0; i < 40 && cmd_load !== 1'b1; i++) tick();
        chk("reach_load", {31'd0, cmd_load}, 32'd1);
    endtask

    task automatic lock_piece();
        filled_under = 1;
        repeat (LOCK_TICKS) begin fall_tick = 1; tick(); fall_tick = 0; tick(); end
        filled_under = 0;
    endtask

    initial begin
        int c0;
        tick(); tick();
        chk("rst_lines", {16'd0, lines_cleared}, 0);
        chk("rst_over", {31'd0, game_over}, 0);
        chk("rst_row", {27'd0, scan_row}, 0);
        chk("rst_load", {31'd0, cmd_load}, 0);

        // start -> load next cycle -> CHECK -> FALL
        resetn = 1; start_game = 1; tick();
        chk("start_load", {31'd0, cmd_load}, 1);
        start_game = 0; tick(); tick();
        chk("fall_no_over", {31'd0, game_over}, 0);

        // three free falls
        c0 = n_down;
        repeat (3) begin fall_tick = 1; tick(); fall_tick = 0; tick(); end
        chk("three_down", n_down - c0, 3);

        // grounded: lock on the second tick
        c0 = n_lock; filled_under = 1;
        fall_tick = 1; tick(); fall_tick = 0; tick();
        chk("no_early_lock", n_lock - c0, 0);
        fall_tick = 1; tick();
        chk("lock", {31'd0, cmd_lock}, 1);
        fall_tick = 0; filled_under = 0; tick();
        chk("scan_from_0", {27'd0, scan_row}, 0);

        // full rows at 0, 0 (after shift) and 5
        c0 = n_clear;
        row_full = 1; tick();
        chk("clear_row0", {31'd0, cmd_clear}, 1);
        row_full = 0; tick();
        row_full = 1; tick();
        row_full = 0; tick();
        chk("rescan_row0", {27'd0, scan_row}, 0);
        wait_row(5);
        row_full = 1; tick();
        row_full = 0;
        chk("lines_3", {16'd0, lines_cleared}, 3);
        tick();
        wait_load();
        chk("three_clear", n_clear - c0, 3);
        tick(); tick();

        // held key acts once
        c0 = n_left; key_left = 1;
        repeat (10) tick();
        key_left = 0; tick();
        chk("held_left_once", n_left - c0, 1);

        // key edge loses to fall_tick and is dropped
        c0 = n_right; key_right = 1; fall_tick = 1; tick();
        chk("tick_wins_down", {31'd0, cmd_down}, 1);
        chk("tick_wins_right", {31'd0, cmd_right}, 0);
        fall_tick = 0; repeat (3) tick();
        key_right = 0; tick();
        chk("edge_dropped", n_right - c0, 0);

        // blocked left move
        c0 = n_left; filled_left = 1; key_left = 1; tick(); tick();
        key_left = 0; filled_left = 0; tick();
        chk("left_blocked", n_left - c0, 0);

        // game over on a blocked spawn
        lock_piece();
        wait_load();
        spawn_blocked = 1; tick(); tick();
        spawn_blocked = 0;
        chk("game_over", {31'd0, game_over}, 1);
        c0 = n_all;
        for (int i = 0; i < 6; i++) begin
            fall_tick = i[0]; key_left = i[1]; key_right = ~i[1]; tick();
        end
        fall_tick = 0; key_left = 0; key_right = 0; tick();
        chk("over_silent", n_all - c0, 0);

        // restart from OVER clears counters; reset in the middle of CLEAR
        start_game = 1; tick();
        chk("restart_load", {31'd0, cmd_load}, 1);
        chk("restart_lines", {16'd0, lines_cleared}, 0);
        chk("restart_over", {31'd0, game_over}, 0);
        start_game = 0; tick(); tick();
        lock_piece();
        wait_row(3);
        row_full = 1; tick();
        chk("clear_row3", {31'd0, cmd_clear}, 1);
        resetn = 0; row_full = 0; tick();
        chk("rst_mid_lines", {16'd0, lines_cleared}, 0);
        chk("rst_mid_row", {27'd0, scan_row}, 0);
        c0 = n_all;
        tick(); resetn = 1; repeat (3) tick();
        chk("idle_silent", n_all - c0, 0);

        // randomized run
        for (int i = 0; i < 4000; i++) begin
            resetn = ($urandom_range(0, 199) != 0);
            start_game = ($urandom_range(0, 15) == 0);
            fall_tick = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 2) == 0) key_left = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 2) == 0) key_right = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 2) == 0) key_rotate = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 3) == 0) key_down = 1'($urandom_range(0, 1));
            filled_under = 1'($urandom_range(0, 1));
            filled_left = ($urandom_range(0, 3) == 0);
            filled_right = ($urandom_range(0, 3) == 0);
            rotation_conflicts = ($urandom_range(0, 3) == 0);
            spawn_blocked = ($urandom_range(0, 9) == 0);
            row_full = ($urandom_range(0, 9) == 0);
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
